chess_layout_reader: RTL

//  Consumer end of the flat chess layout bus. On a start request it snapshots the

---
 rtl/chess_layout_reader.sv | 100 ++++++++++
 1 files changed

// File: rtl/chess_layout_reader.sv
// Snapshots the flat chess layout on Start and streams one square code per valid/ready
// transfer (index 0 first), counting non-empty squares; Done pulses once after the last transfer.
module chess_layout_reader #(
    parameter int                     CHESS_SQUARES = 64,
    parameter int                     SQUARE_WIDTH  = 8,
    parameter int                     MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH,
    parameter int                     INDEX_WIDTH   = 6,
    parameter logic [SQUARE_WIDTH-1:0] EMPTY_CODE   = '0
) (
    input  logic                    clock,
    input  logic                    resetApp,
    input  logic [MATRIX_WIDTH-1:0] Layout,
    input  logic                    Start,
    input  logic                    SqReady,
    output logic                    SqValid,
    output logic [INDEX_WIDTH-1:0]  SqIndex,
    output logic [SQUARE_WIDTH-1:0] SqCode,
    output logic                    SqLast,
    output logic                    Busy,
    output logic                    Done,
    output logic [INDEX_WIDTH:0]    PieceCount
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(CHESS_SQUARES - 1);

    state_t                  state_q, state_d;
    logic [MATRIX_WIDTH-1:0] snap_q, snap_d;
    logic [INDEX_WIDTH-1:0]  idx_q, idx_d;
    logic [INDEX_WIDTH:0]    cnt_q, cnt_d;
    logic [SQUARE_WIDTH-1:0] cur_code;

    assign cur_code = snap_q[idx_q * SQUARE_WIDTH +: SQUARE_WIDTH];

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    snap_d  = Layout;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // SqValid is constant high here, so SqReady alone marks a transfer.
                if (SqReady) begin
                    if (cur_code != EMPTY_CODE) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            state_q <= IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Code is gated so the bus reads zero outside a scan, not a stale snapshot byte.
    assign SqValid    = (state_q == STREAM);
    assign Busy       = (state_q == STREAM);
    assign Done       = (state_q == DONE);
    assign SqIndex    = idx_q;
    assign SqCode     = SqValid ? cur_code : '0;
    assign SqLast     = SqValid && (idx_q == LAST_IDX);
    assign PieceCount = cnt_q;

endmodule
